// File: rtl/mips_pkg.sv
// Shared register-file types and constants for the MIPS core slice.
package mips_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_lookup.sv
// Youngest-match search over the writeback queue for one register read port.
module wb_lookup
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = mips_pkg::AW,
    parameter int DW    = mips_pkg::DW,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [PW-1:0]             head,
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH-1:0][AW-1:0]  addrs,
    input  logic [DEPTH-1:0][DW-1:0]  datas,
    input  logic [AW-1:0]             ra,
    output logic                      hit,
    output logic [DW-1:0]             data
);
    // Walk oldest to youngest so the last match seen is the one nearest tail.
    always_comb begin
        logic [PW-1:0] idx;
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (addrs[idx] == ra) && (ra != AW'(REG_ZERO))) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end
endmodule

// File: rtl/wb_queue.sv
// Writeback queue feeding the regfile write port when the primary writeback is idle.
// Optional WBQ_COALESCE_EN: pushes to an already-queued register overwrite it in place.
module wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = mips_pkg::AW,
    parameter int DW    = mips_pkg::DW,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          rf_stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] q_ra1,
    input  logic [AW-1:0] q_ra2,
    output logic          q_hit1,
    output logic          q_hit2,
    output logic [DW-1:0] q_data1,
    output logic [DW-1:0] q_data2,
    output logic [CW-1:0] count
);
    logic [DEPTH-1:0][AW-1:0] addr_q;
    logic [DEPTH-1:0][DW-1:0] data_q;
    logic [DEPTH-1:0]         valid_q;
    logic [PW-1:0]            head_q, tail_q;
    logic [CW-1:0]            count_q, count_d;
    logic                     not_empty, not_full, pop, push_new, push_ok;

    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != CW'(DEPTH));
    assign pop       = not_empty && !rf_stall;
    assign push_ok   = in_valid && in_ready && (in_addr != AW'(REG_ZERO));

    assign rf_we = pop;
    assign rf_wa = not_empty ? addr_q[head_q] : '0;
    assign rf_wd = not_empty ? data_q[head_q] : '0;
    assign count = count_q;

`ifdef WBQ_COALESCE_EN
    logic          coal_hit;
    logic [PW-1:0] coal_idx;

    // The head slot is excluded while it pops: its data is already committing.
    always_comb begin
        logic [PW-1:0] idx;
        coal_hit = 1'b0;
        coal_idx = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (valid_q[idx] && (addr_q[idx] == in_addr) && !(pop && (idx == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
        end
    end

    assign in_ready = not_full || (in_valid && coal_hit);
    assign push_new = push_ok && !coal_hit;
`else
    assign in_ready = not_full;
    assign push_new = push_ok;
`endif

    assign count_d = count_q + CW'(push_new) - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push_new) begin
                addr_q[tail_q]  <= in_addr;
                data_q[tail_q]  <= in_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
`ifdef WBQ_COALESCE_EN
            if (push_ok && coal_hit) begin
                data_q[coal_idx] <= in_data;
            end
`endif
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    wb_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_lookup1 (
        .head  (head_q),
        .valid (valid_q),
        .addrs (addr_q),
        .datas (data_q),
        .ra    (q_ra1),
        .hit   (q_hit1),
        .data  (q_data1)
    );

    wb_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW)) u_lookup2 (
        .head  (head_q),
        .valid (valid_q),
        .addrs (addr_q),
        .datas (data_q),
        .ra    (q_ra2),
        .hit   (q_hit2),
        .data  (q_data2)
    );
endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: reset, drain, full, lookup, zero-address, flush/reset, wrap.
module tb_wb_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAW   = 5;
    localparam int TDW   = 32;
    localparam int TCW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           reset, flush, in_valid, in_ready, rf_stall, rf_we;
    logic [TAW-1:0] in_addr, rf_wa, q_ra1, q_ra2;
    logic [TDW-1:0] in_data, rf_wd, q_data1, q_data2;
    logic           q_hit1, q_hit2;
    logic [TCW-1:0] count;

    int errors = 0;
    int checks = 0;
    logic [TAW+TDW-1:0] exp_q[$];

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(DEPTH), .AW(TAW), .DW(TDW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .rf_stall(rf_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .q_ra1(q_ra1), .q_ra2(q_ra2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2), .count(count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TAW-1:0] a, input logic [TDW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        rf_stall = 1'b0; q_ra1 = 5'd0; q_ra2 = 5'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if ({rf_wa, rf_wd} !== '0) begin errors++; $display("FAIL reset_rf_wawd got=%h/%h exp=0/0", rf_wa, rf_wd); end
        q_ra1 = 5'd5; q_ra2 = 5'd1; #1;
        checks++; if ({q_hit1, q_hit2, q_data1, q_data2} !== '0) begin errors++; $display("FAIL reset_lookup got=%b%b %h %h exp=0", q_hit1, q_hit2, q_data1, q_data2); end
        q_ra1 = 5'd0; q_ra2 = 5'd0;
    endtask

    task automatic test_single();
        rf_stall = 1'b0;
        push(5'd5, 32'h1234_5678);
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", rf_we); end
        checks++; if (rf_wa !== 5'd5) begin errors++; $display("FAIL single_wa got=%0d exp=5", rf_wa); end
        checks++; if (rf_wd !== 32'h1234_5678) begin errors++; $display("FAIL single_wd got=%h exp=12345678", rf_wd); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got=%0d exp=1", count); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0 got=%0d exp=0", count); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we0 got=%b exp=0", rf_we); end
    endtask

    task automatic test_full();
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(TAW'(i), TDW'(9 + i));
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", in_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL full_stall_we got=%b exp=0", rf_we); end
        q_ra1 = 5'd2; #1;
        checks++; if ({q_hit1, q_data1} !== {1'b1, 32'hB}) begin errors++; $display("FAIL full_lookup got=%b/%h exp=1/b", q_hit1, q_data1); end
        q_ra1 = 5'd0;
        in_valid = 1'b1; in_addr = 5'd9; in_data = 32'hFF; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready5 got=%b exp=0", in_ready); end
        tick();
        in_valid = 1'b0; #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count5 got=%0d exp=4", count); end
        rf_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (rf_we !== 1'b1 || rf_wa !== TAW'(i) || rf_wd !== TDW'(9 + i)) begin
                errors++; $display("FAIL full_drain%0d got=%b/%0d/%h exp=1/%0d/%h", i, rf_we, rf_wa, rf_wd, i, 9 + i);
            end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", count); end
    endtask

    task automatic test_lookup();
        wb_entry_t e;
        rf_stall = 1'b1;
        push(5'd3, 32'h11);
        push(5'd3, 32'h22);
`ifdef WBQ_COALESCE_EN
        exp_q.push_back({5'd3, 32'h22});
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL coal_count got=%0d exp=1", count); end
`else
        exp_q.push_back({5'd3, 32'h11});
        exp_q.push_back({5'd3, 32'h22});
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL lookup_count got=%0d exp=2", count); end
`endif
        q_ra1 = 5'd3; q_ra2 = 5'd7; #1;
        checks++; if ({q_hit1, q_data1} !== {1'b1, 32'h22}) begin errors++; $display("FAIL lookup_hit1 got=%b/%h exp=1/22", q_hit1, q_data1); end
        checks++; if ({q_hit2, q_data2} !== {1'b0, 32'h0}) begin errors++; $display("FAIL lookup_miss2 got=%b/%h exp=0/0", q_hit2, q_data2); end
        q_ra1 = 5'd0; #1;
        checks++; if ({q_hit1, q_data1} !== {1'b0, 32'h0}) begin errors++; $display("FAIL lookup_zero got=%b/%h exp=0/0", q_hit1, q_data1); end
        q_ra1 = 5'd3;
        rf_stall = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            #1;
            checks++;
            if (rf_we !== 1'b1 || rf_wa !== e.addr || rf_wd !== e.data || q_hit1 !== 1'b1) begin
                errors++; $display("FAIL lookup_drain got=%b/%0d/%h hit=%b exp=1/%0d/%h hit=1", rf_we, rf_wa, rf_wd, q_hit1, e.addr, e.data);
            end
            tick();
        end
        checks++; if ({count, rf_we, q_hit1} !== 5'b0) begin errors++; $display("FAIL lookup_empty got=%0d/%b/%b exp=0/0/0", count, rf_we, q_hit1); end
        q_ra1 = 5'd0; q_ra2 = 5'd0;
    endtask

    task automatic test_zero_addr();
        rf_stall = 1'b0;
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hDEAD; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (count !== 3'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL zero_drop got=%0d/%b exp=0/0", count, rf_we); end
            tick();
        end
    endtask

    task automatic test_flush_reset();
        rf_stall = 1'b1;
        push(5'd10, 32'hA0);
        push(5'd11, 32'hA1);
        push(5'd12, 32'hA2);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_fill got=%0d exp=3", count); end
        flush = 1'b1; in_valid = 1'b1; in_addr = 5'd13; in_data = 32'hA3;
        tick();
        flush = 1'b0; in_valid = 1'b0; rf_stall = 1'b0; #1;
        checks++; if (count !== 3'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL flush_clear got=%0d/%b exp=0/0", count, rf_we); end
        rf_stall = 1'b1;
        push(5'd14, 32'hB0);
        push(5'd15, 32'hB1);
        rf_stall = 1'b0; #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd14) begin errors++; $display("FAIL rst_middrain got=%b/%0d exp=1/14", rf_we, rf_wa); end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        checks++; if (count !== 3'd0 || rf_we !== 1'b0) begin errors++; $display("FAIL rst_clear got=%0d/%b exp=0/0", count, rf_we); end
    endtask

    task automatic test_back_to_back();
        wb_entry_t e;
        rf_stall = 1'b0;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            in_valid = 1'b1;
            in_addr  = TAW'(k + 1);
            in_data  = 32'hC000 + 32'(k);
            #1;
            if (k > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (count !== 3'd1 || rf_we !== 1'b1 || rf_wa !== e.addr || rf_wd !== e.data) begin
                    errors++; $display("FAIL b2b_%0d got=%0d/%b/%0d/%h exp=1/1/%0d/%h", k, count, rf_we, rf_wa, rf_wd, e.addr, e.data);
                end
            end
            exp_q.push_back({in_addr, in_data});
            tick();
        end
        in_valid = 1'b0;
        e = exp_q.pop_front(); #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== e.addr || rf_wd !== e.data) begin errors++; $display("FAIL b2b_last got=%b/%0d/%h exp=1/%0d/%h", rf_we, rf_wa, rf_wd, e.addr, e.data); end
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_lookup();
        test_zero_addr();
        test_flush_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
